reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised multi-channel reset generator for the FPGA top levels; it replaces the single-output boot reset. It holds every downstream reset domain (controller, core, peripherals) in reset after power-up, an external button press or a controller soft-reset request. It then releases the domains one at a time, in ascending channel order, with a programmable gap between releases.

## Interface
- CHANNELS, 3: number of reset outputs; 1..16.
- CYCLES, 20: cycles each stage lasts (initial hold and gap between releases); ≥1.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles needed for ext_reset_req to change debounced level; ≥1.
- clk  in  1  single system clock (25 MHz on ECP5 boards).
- reset  in  1  asynchronous, active-low board/power-on reset; assertion is asynchronous, deassertion is synchronised internally (2 flops).
- ext_reset_req  in  1  asynchronous active-high button; 2-flop synchronised then debounced.
- soft_reset_req  in  1  synchronous single-cycle pulse from the controller.
- soft_reset_mask  in  CHANNELS  channels to reset on soft_reset_req; sampled with the pulse.
- reset_o  out  CHANNELS  active-high resets, one per domain.
- all_released  out  1  high when every reset_o bit is 0.
- busy  out  1  high while the sequencer is in HOLD or RELEASE.

## Operation
- Internal state:
  - `pending[CHANNELS]`: channels still to be released.
  - Stage counter: clog2(CYCLES+1) bits.
  - Channel index: clog2(CHANNELS) bits, minimum 1 bit.
  - Debounce counter: clog2(DEBOUNCE_CYCLES+1) bits.
- Values while reset is low: `reset_o` = all 1, `pending` = all 1, `all_released` = 0, `busy` = 1, state = HOLD, counters = 0, debounced ext level = 0.
- Each `reset_o[k]` is a register, so there are no glitches. It equals `pending[k]`.
- States:
  - HOLD: hold phase.
    - Counter counts 0..CYCLES-1.
    - At CYCLES-1: index ← lowest set bit of pending, counter ← 0, go to RELEASE.
  - RELEASE: counter is 0 on entry.
    - On entry the cycle clears `pending[index]`.
    - Then the counter counts to CYCLES-1 and index advances to the next set pending bit.
    - When no pending bit remains, go to RUN.
  - RUN: all channels that were sequenced are released. `busy` = 0.
- Debounce:
  - The synchronised ext_reset_req must differ from the debounced level for DEBOUNCE_CYCLES consecutive cycles before the debounced level flips.
  - Any cycle with no difference resets the debounce counter.
- While debounced ext is high:
  - pending = all 1, state = HOLD, counter held at 0.
  - `reset_o` stays all 1.
- Debounced ext falling: the HOLD count starts on the next cycle.
- soft_reset_req:
  - pending ← pending | soft_reset_mask, state ← HOLD, counter ← 0.
  - This applies from any state. Channels outside the mask keep their current value.
  - A mask of 0 is a no-op: state and outputs are unchanged.
- Priority: reset > debounced ext > soft_reset_req > normal sequencing.
- A soft request during RELEASE restarts the hold phase. Already-released channels not in the mask stay released.

## Timing
- Edge numbering: edge 0 is the first clk edge on which the synchronised internal reset is deasserted. This is 2 edges after the reset pin rises.
- Full sequence: `reset_o[k]` falls after edge CYCLES·(k+1), where k is the rank among pending channels.
- Completion: `all_released` rises and `busy` falls on the same edge that clears the last pending bit.
- Soft request sampled at edge t: masked bits of `reset_o` are 1 after edge t. The first masked channel is released after edge t+CYCLES.
- Debounce latency: DEBOUNCE_CYCLES + 2 edges from the ext pin changing to the debounced level changing.
- Asynchronous reset mid-sequence: all outputs return to reset values immediately, with no clock needed.

## Test plan
Bench parameters: CHANNELS=3, CYCLES=4, DEBOUNCE_CYCLES=3.
- Power-up:
  - Stimulus: reset low for 5 cycles, then high.
  - Response: `reset_o` = 111 while low. After 2 sync edges, `reset_o` = 110 after edge 4, 100 after edge 8, 000 after edge 12. `all_released`=1 and `busy`=0 with the last release.
- Mid-sequence reset:
  - Stimulus: after `reset_o` reaches 110, drive reset low asynchronously (between edges).
  - Response: `reset_o` = 111 before the next edge, then the sequence replays from 111.
- Soft reset from RUN:
  - Stimulus: soft_reset_req with mask 100.
  - Response: `reset_o` = 100 next edge, `busy`=1, back to 000 four edges later. Bits 0 and 1 never toggle.
- Ext glitch and real press:
  - Glitch: 2-cycle ext pulse → no effect.
  - Real press: 10-cycle pulse. Response: `reset_o` = 111 five edges after the rise, then full 4/8/12 sequence after the debounced fall.
- Simultaneous and mid-sequence requests:
  - Soft mask 011 on the same edge as debounced ext high → ext wins, `reset_o` = 111.
  - Soft mask 001 during RELEASE with `reset_o` = 100 → `reset_o` = 101, then 100 after 4 edges, then 000 after 4 more.
- Zero mask:
  - Stimulus: soft mask 000 pulse in RUN.
  - Response: no change, `busy` stays 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: holds all downstream domains in reset, then
// releases them one at a time in ascending channel order with a fixed gap.
module reset_sequencer #(
  parameter int CHANNELS        = 3,
  parameter int CYCLES          = 20,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ext_reset_req,
  input  logic                soft_reset_req,
  input  logic [CHANNELS-1:0] soft_reset_mask,
  output logic [CHANNELS-1:0] reset_o,
  output logic                all_released,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t              state;
  logic [CHANNELS-1:0] pending;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic                ext_meta;
  logic                ext_sync;
  logic                deb_q;
  logic [DEB_W-1:0]    deb_cnt;
  logic                deb_flip;
  logic                ext_active;

  logic                soft_hit;
  logic [CHANNELS-1:0] pend_soft;
  logic [CHANNELS-1:0] pend_clr;
  logic [CHANNELS-1:0] rel_next;

  function automatic logic [IDX_W-1:0] lowest(input logic [CHANNELS-1:0] v);
    lowest = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDX_W'(i);
    end
  endfunction

  // Assertion is immediate through the async clear; release waits two edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_meta <= 1'b0;
      ext_sync <= 1'b0;
      deb_q    <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      ext_meta <= ext_reset_req;
      ext_sync <= ext_meta;
      if (ext_sync != deb_q) begin
        if (deb_flip) begin
          deb_q   <= ~deb_q;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign deb_flip   = (ext_sync != deb_q) && (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
  // A rising flip takes effect on the same edge as the debounced level change.
  assign ext_active = deb_q | deb_flip;

  assign soft_hit  = soft_reset_req && (|soft_reset_mask);
  assign pend_soft = pending | soft_reset_mask;
  assign pend_clr  = pending & ~(CHANNELS'(1) << idx);
  assign rel_next  = (cnt == '0) ? pend_clr : pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HOLD;
      pending      <= '1;
      cnt          <= '0;
      idx          <= '0;
      reset_o      <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else if (ext_active) begin
      state        <= HOLD;
      pending      <= '1;
      cnt          <= '0;
      reset_o      <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else if (soft_hit) begin
      pending      <= pend_soft;
      reset_o      <= pend_soft;
      all_released <= 1'b0;
      busy         <= 1'b1;
      // The request cycle itself is the first hold cycle.
      if (CYCLES == 1) begin
        state <= RELEASE;
        cnt   <= '0;
        idx   <= lowest(pend_soft);
      end else begin
        state <= HOLD;
        cnt   <= CNT_W'(1);
      end
    end else begin
      case (state)
        HOLD: begin
          if (cnt == CNT_W'(CYCLES - 1)) begin
            cnt <= '0;
            idx <= lowest(pending);
            if (pending == '0) begin
              state        <= RUN;
              all_released <= 1'b1;
              busy         <= 1'b0;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            pending <= pend_clr;
            reset_o <= pend_clr;
          end
          if (rel_next == '0) begin
            state        <= RUN;
            cnt          <= '0;
            all_released <= 1'b1;
            busy         <= 1'b0;
          end else if (cnt == CNT_W'(CYCLES - 1)) begin
            cnt <= '0;
            idx <= lowest(rel_next);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          busy <= 1'b0;
        end
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer (CHANNELS=3, CYCLES=4, DEBOUNCE_CYCLES=3):
// expected {reset_o, all_released, busy} per edge are queued, then popped and compared.
module tb_reset_sequencer;

  localparam int CH = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ext_reset_req = 1'b0;
  logic          soft_reset_req = 1'b0;
  logic [CH-1:0] soft_reset_mask = '0;
  logic [CH-1:0] reset_o;
  logic          all_released;
  logic          busy;
  logic [1:0]    state_dbg;

  logic [4:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  reset_sequencer #(.CHANNELS(CH), .CYCLES(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk(clk),
    .reset(reset),
    .ext_reset_req(ext_reset_req),
    .soft_reset_req(soft_reset_req),
    .soft_reset_mask(soft_reset_mask),
    .reset_o(reset_o),
    .all_released(all_released),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Full sequence with edge e counted from the first counting edge.
  function automatic logic [4:0] seq_exp(input int e);
    if (e < 4)       return {3'b111, 1'b0, 1'b1};
    else if (e < 8)  return {3'b110, 1'b0, 1'b1};
    else if (e < 12) return {3'b100, 1'b0, 1'b1};
    else             return {3'b000, 1'b1, 1'b0};
  endfunction

  task automatic test_reset();
    logic [4:0] got, want;
    for (int i = 0; i < 5; i++) exp_q.push_back({3'b111, 1'b0, 1'b1});
    for (int i = 0; i < 17; i++) exp_q.push_back(seq_exp(i - 2));
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      got  = {reset_o, all_released, busy};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL power_up cyc %0d: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
                 i, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
      end
      if (i == 2) begin
        n_cmp++;
        if (state_dbg !== 2'd0) begin
          n_err++;
          $display("FAIL power_up_state: got %0d, expected 0", state_dbg);
        end
      end
      if (i == 4) reset = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] got, want;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(seq_exp(i - 2));
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      got  = {reset_o, all_released, busy};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL mid_reset_pre cyc %0d: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
                 i, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
      end
    end
    // Now at 110: pull reset low between edges.
    #2 reset = 1'b0;
    exp_q.push_back({3'b111, 1'b0, 1'b1});
    #1;
    got  = {reset_o, all_released, busy};
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL mid_reset_async: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
               got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 17; i++) exp_q.push_back(seq_exp(i - 2));
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      got  = {reset_o, all_released, busy};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL mid_reset_replay cyc %0d: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
                 i, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_soft_run();
    logic [4:0] got, want;
    for (int i = 0; i < 8; i++)
      exp_q.push_back(i < 4 ? {3'b100, 1'b0, 1'b1} : {3'b000, 1'b1, 1'b0});
    soft_reset_req  = 1'b1;
    soft_reset_mask = 3'b100;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      soft_reset_req  = 1'b0;
      soft_reset_mask = 3'(0);
      got  = {reset_o, all_released, busy};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL soft_run cyc %0d: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
                 i, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_zero_mask();
    logic [4:0] got, want;
    for (int i = 0; i < 6; i++) exp_q.push_back({3'b000, 1'b1, 1'b0});
    soft_reset_req  = 1'b1;
    soft_reset_mask = 3'b000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      soft_reset_req = 1'b0;
      got  = {reset_o, all_released, busy};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL zero_mask cyc %0d: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
                 i, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_ext_glitch();
    logic [4:0] got, want;
    for (int i = 0; i < 10; i++) exp_q.push_back({3'b000, 1'b1, 1'b0});
    for (int i = 0; i < 10; i++) begin
      ext_reset_req = (i < 2);
      @(posedge clk); #1;
      got  = {reset_o, all_released, busy};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL ext_glitch cyc %0d: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
                 i, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
      end
    end
    ext_reset_req = 1'b0;
  endtask

  // 10-cycle press: debounced high after edge 4, debounced low after edge 14,
  // so the hold count starts at edge 15. Optional soft request on edge 4.
  task automatic test_ext_press(input bit with_soft);
    logic [4:0] got, want;
    for (int k = 0; k < 30; k++)
      exp_q.push_back(k < 4 ? {3'b000, 1'b1, 1'b0} : seq_exp(k - 15));
    for (int k = 0; k < 30; k++) begin
      ext_reset_req   = (k < 10);
      soft_reset_req  = with_soft && (k == 4);
      soft_reset_mask = (with_soft && (k == 4)) ? 3'b011 : 3'b000;
      @(posedge clk); #1;
      got  = {reset_o, all_released, busy};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL ext_press%s cyc %0d: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
                 with_soft ? "_soft" : "", k, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
      end
    end
    soft_reset_req  = 1'b0;
    soft_reset_mask = 3'b000;
    ext_reset_req   = 1'b0;
  endtask

  task automatic test_soft_mid_release();
    logic [4:0] got, want;
    for (int k = 0; k < 20; k++) begin
      if (k < 4)       exp_q.push_back({3'b111, 1'b0, 1'b1});
      else if (k < 8)  exp_q.push_back({3'b110, 1'b0, 1'b1});
      else if (k < 9)  exp_q.push_back({3'b100, 1'b0, 1'b1});
      else if (k < 13) exp_q.push_back({3'b101, 1'b0, 1'b1});
      else if (k < 17) exp_q.push_back({3'b100, 1'b0, 1'b1});
      else             exp_q.push_back({3'b000, 1'b1, 1'b0});
    end
    for (int k = 0; k < 20; k++) begin
      soft_reset_req  = (k == 0) || (k == 9);
      soft_reset_mask = (k == 0) ? 3'b111 : ((k == 9) ? 3'b001 : 3'b000);
      @(posedge clk); #1;
      got  = {reset_o, all_released, busy};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL soft_mid_release cyc %0d: got ro=%b ar=%b busy=%b, expected ro=%b ar=%b busy=%b",
                 k, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
      end
    end
    soft_reset_req  = 1'b0;
    soft_reset_mask = 3'b000;
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_soft_run();
    test_zero_mask();
    test_ext_glitch();
    test_ext_press(1'b0);
    test_ext_press(1'b1);
    test_soft_mid_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t, expected to finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
